// File: rtl/csa_resolve_seq.sv
// ============================================================================
// Module   : csa_resolve_seq
// Purpose  : Final carry-propagate stage for the multiplier carry-save tree.
//            Resolves one (sum, carry) vector pair to binary, CHUNK bits per
//            cycle, LSB chunk first, with a registered inter-chunk carry.
// Options  : CSA_RESOLVE_EARLY_DONE_EN - finish as soon as the remaining
//            upper bits of both vectors are zero and no carry is pending.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_resolve_seq #(
  parameter int WIDTH = 38,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_vec,
  input  logic [WIDTH-1:0] carry_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int EXT    = NCHUNK * CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [EXT-1:0]   r_sum;
  logic [EXT-1:0]   r_carry;
  // Bit EXT holds the carry out of the last chunk; when WIDTH is a whole
  // number of chunks it becomes result[WIDTH], otherwise it is always zero.
  logic [EXT:0]     r_res;
  logic [EXT:0]     w_res_next;
  logic             r_c;
  logic [IDX_W-1:0] r_idx;

  logic [CHUNK-1:0] w_sum_chunk;
  logic [CHUNK-1:0] w_carry_chunk;
  logic [CHUNK:0]   w_add;
  logic             w_last;
  logic             w_early;

  // Pick the operand chunks addressed by the current index.
  always_comb begin
    w_sum_chunk   = '0;
    w_carry_chunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_sum_chunk   = r_sum[k*CHUNK +: CHUNK];
        w_carry_chunk = r_carry[k*CHUNK +: CHUNK];
      end
    end
  end

  assign w_add  = {1'b0, w_sum_chunk} + {1'b0, w_carry_chunk} + {{CHUNK{1'b0}}, r_c};
  assign w_last = (r_idx == IDX_W'(NCHUNK - 1));

`ifdef CSA_RESOLVE_EARLY_DONE_EN
  logic [EXT-1:0] w_or;
  logic           w_upper_zero;

  assign w_or = r_sum | r_carry;

  // Nothing left to add above the current chunk in either vector.
  always_comb begin
    w_upper_zero = 1'b1;
    for (int b = 0; b < EXT; b++) begin
      if ((b >= (int'(r_idx) + 1) * CHUNK) && w_or[b]) begin
        w_upper_zero = 1'b0;
      end
    end
  end

  assign w_early = w_upper_zero && !w_add[CHUNK];
`else
  assign w_early = 1'b0;
`endif

  // Merge the freshly added chunk into the accumulated result.
  always_comb begin
    w_res_next = r_res;
    for (int k = 0; k < NCHUNK; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_res_next[k*CHUNK +: CHUNK] = w_add[CHUNK-1:0];
      end
    end
    if (w_last) begin
      w_res_next[EXT] = w_add[CHUNK];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)          w_state_next = S_RUN;
      S_RUN:   if (w_last || w_early) w_state_next = S_DONE;
      S_DONE:  if (out_ready)         w_state_next = S_IDLE;
      default:                        w_state_next = S_IDLE;
    endcase
  end

  // Handshake outputs depend only on the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Operand capture and chunk-serial accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_carry <= '0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sum   <= EXT'(sum_vec);
            r_carry <= EXT'(carry_vec);
            r_res   <= '0;
            r_c     <= 1'b0;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_res <= w_res_next;
          r_c   <= w_add[CHUNK];
          if (!w_last) begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: begin
          r_res <= r_res;
        end
      endcase
    end
  end

  assign result = r_res[WIDTH:0];

  generate
    if (EXT > WIDTH) begin : g_pad
      logic w_unused_pad;
      assign w_unused_pad = ^r_res[EXT:WIDTH+1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_csa_resolve_seq.sv
// ============================================================================
// Module   : tb_csa_resolve_seq
// Purpose  : Self-checking bench for csa_resolve_seq (WIDTH=38, CHUNK=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csa_resolve_seq;

  localparam int WIDTH  = 38;
  localparam int NCHUNK = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] sum_vec = '0;
  logic [WIDTH-1:0] carry_vec = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH:0]   result;

  int n_tests = 0;
  int n_fail  = 0;

  csa_resolve_seq #(.WIDTH(WIDTH), .CHUNK(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_vec   (sum_vec),
    .carry_vec (carry_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycles from the accept edge until out_valid, from the arithmetic meaning
  // of the early-exit rule: stop after chunk k once nothing is left above it.
  function automatic int model_lat(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
`ifdef CSA_RESOLVE_EARLY_DONE_EN
    logic [63:0] sv, cv, msk, part;
    sv = 64'(s);
    cv = 64'(c);
    for (int k = 0; k < NCHUNK; k++) begin
      msk  = (64'd1 << ((k + 1) * 8)) - 64'd1;
      part = (sv & msk) + (cv & msk);
      if (((sv | cv) >> ((k + 1) * 8)) == 64'd0 && part[(k + 1) * 8] == 1'b0)
        return k + 1;
    end
    return NCHUNK;
`else
    return (s === s) ? NCHUNK : NCHUNK;
`endif
  endfunction

  // Reference model: transaction-level view of the block, checked every cycle.
  bit          m_busy = 1'b0;
  int          m_cnt  = 0;
  int          m_lat  = 0;
  logic [63:0] m_res  = '0;

  always @(negedge clk) begin
    logic exp_ov;
    if (!rst_n) begin
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      m_busy = 1'b0;
    end else begin
      exp_ov = m_busy && (m_cnt >= m_lat);
      chk("in_ready", 64'(in_ready), 64'(!m_busy));
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      if (exp_ov) chk("result", 64'(result), m_res);
      if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1'b1;
          m_cnt  = 0;
          m_res  = 64'(sum_vec) + 64'(carry_vec);
          m_lat  = model_lat(sum_vec, carry_vec);
        end
      end else if (exp_ov) begin
        if (out_ready) m_busy = 1'b0;
      end else begin
        m_cnt++;
      end
    end
  end

  function automatic logic [WIDTH-1:0] rnd_vec();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[WIDTH-1:0];
  endfunction

  // One full transaction; lit=1 additionally pins hand-computed values.
  task automatic send(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                      input bit lit, input logic [WIDTH:0] exp_res,
                      input int exp_lat, input int hold, input string tag);
    bit ok;
    int k;
    @(posedge clk); #2;
    sum_vec = s; carry_vec = c; in_valid = 1'b1; out_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk({tag, "_accept_timeout"}, 64'd0, 64'd1);
    @(posedge clk); #2;
    in_valid = 1'b0; sum_vec = rnd_vec(); carry_vec = rnd_vec();
    ok = 1'b0; k = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; k = i; break; end
    end
    if (!ok) chk({tag, "_done_timeout"}, 64'd0, 64'd1);
    if (lit) begin
      chk({tag, "_latency"}, 64'(k), 64'(exp_lat));
      chk({tag, "_result"}, 64'(result), 64'(exp_res));
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #2;
      in_valid = 1'b1; sum_vec = rnd_vec(); carry_vec = rnd_vec();
      @(negedge clk);
      if (lit) begin
        chk({tag, "_hold_result"}, 64'(result), 64'(exp_res));
        chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      end
    end
    @(posedge clk); #2;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    if (lit) begin
      @(negedge clk);
      chk({tag, "_released_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_released_in_ready"}, 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] wide;
    bit ok;
    int p;
    logic [WIDTH-1:0] s, c;

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

`ifdef CSA_RESOLVE_EARLY_DONE_EN
    send(38'hFF, 38'h01, 1'b1, 39'h100, 2, 0, "t1");
`else
    send(38'hFF, 38'h01, 1'b1, 39'h100, 5, 0, "t1");
`endif
    send(38'h3F_FFFF_FFFF, 38'h1, 1'b1, 39'h40_0000_0000, 5, 0, "t2");
    send(38'h3F_FFFF_FFFF, 38'h3F_FFFF_FFFF, 1'b1, 39'h7F_FFFF_FFFE, 5, 0, "t3");
`ifdef CSA_RESOLVE_EARLY_DONE_EN
    send(38'hFF, 38'h01, 1'b1, 39'h100, 2, 3, "t4");
`else
    send(38'hFF, 38'h01, 1'b1, 39'h100, 5, 3, "t4");
`endif

    // Reset during the third RUN cycle.
    @(posedge clk); #2;
    sum_vec = 38'hAB_CDEF_0123; carry_vec = 38'h11_1111_1111; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("t5_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #2 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    chk("t5_abort_out_valid", 64'(out_valid), 64'd0);
    chk("t5_abort_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #2 rst_n = 1'b1;
`ifdef CSA_RESOLVE_EARLY_DONE_EN
    send(38'h12, 38'h34, 1'b1, 39'h46, 1, 0, "t5");
`else
    send(38'h12, 38'h34, 1'b1, 39'h46, 5, 0, "t5");
`endif

    // Upper-chunk-only operand; the 40-bit constant truncates to 38 bits.
    wide = 40'hFF_0000_0000;
    send(wide[WIDTH-1:0], 38'h0, 1'b1, 39'h3F_0000_0000, 5, 0, "t6");

    // Randomized traffic checked by the reference model.
    for (int n = 0; n < 60; n++) begin
      p = $urandom_range(0, 4);
      case (p)
        0: begin s = rnd_vec(); c = rnd_vec(); end
        1: begin s = '1; c = rnd_vec(); end
        2: begin s = WIDTH'($urandom_range(0, 255)); c = WIDTH'($urandom_range(0, 255)); end
        3: begin s = rnd_vec() & (WIDTH'(38'hFF) << (8 * $urandom_range(0, 4))); c = '0; end
        default: begin s = rnd_vec() & WIDTH'(38'hFFFF); c = rnd_vec() & WIDTH'(38'hFFFF); end
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(s, c, 1'b0, '0, 0, $urandom_range(0, 3), "rnd");
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
